// File: rtl/if_fetch_unit_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package if_fetch_unit_pkg;

    typedef enum logic [1:0] {
        StStart,
        StFetch,
        StDone,
        StDiscard
    } fetch_state_e;

    localparam int unsigned INST_BYTES = 4;
    localparam logic [31:0] NOP_INST   = 32'h0000_0013;
    localparam int unsigned STALL_BIT  = 0;
    localparam int unsigned FLUSH_BIT  = 1;

endpackage

// File: rtl/if_fetch_unit_if.sv
// Wishbone classic bus bundle between the fetch stage (master) and instruction memory (slave).
interface if_fetch_unit_if #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32
) ();

    logic                    wb_cyc_o;
    logic                    wb_stb_o;
    logic                    wb_we_o;
    logic [DATA_WIDTH/8-1:0] wb_sel_o;
    logic [ADDR_WIDTH-1:0]   wb_adr_o;
    logic [DATA_WIDTH-1:0]   wb_dat_i;
    logic                    wb_ack_i;

    modport master (
        output wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o, wb_adr_o,
        input  wb_dat_i, wb_ack_i
    );

    modport slave (
        input  wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o, wb_adr_o,
        output wb_dat_i, wb_ack_i
    );

endinterface

// File: rtl/if_fetch_unit_wb_master.sv
// Wishbone classic single-read master: a start pulse opens a cycle at addr_i, which stays
// registered and asserted until the slave acknowledges.
module if_wb_master
    import if_fetch_unit_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start_i,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    output logic                  ack_o,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  busy_o,
    if_fetch_unit_if.master       wb
);

    logic                  cyc_q, cyc_d;
    logic [ADDR_WIDTH-1:0] adr_q, adr_d;

    // A start in the ack cycle chains straight into the next transfer.
    always_comb begin
        cyc_d = cyc_q;
        adr_d = adr_q;
        if (cyc_q && wb.wb_ack_i) begin
            cyc_d = 1'b0;
        end
        if (start_i) begin
            cyc_d = 1'b1;
            adr_d = addr_i;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cyc_q <= 1'b0;
            adr_q <= '0;
        end else begin
            cyc_q <= cyc_d;
            adr_q <= adr_d;
        end
    end

    assign wb.wb_cyc_o = cyc_q;
    assign wb.wb_stb_o = cyc_q;
    assign wb.wb_we_o  = 1'b0;
    assign wb.wb_sel_o = '1;
    assign wb.wb_adr_o = adr_q;

    assign ack_o  = cyc_q & wb.wb_ack_i;
    assign data_o = wb.wb_dat_i;
    assign busy_o = cyc_q;

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC and runs one Wishbone read per instruction.
// Optional misaligned-redirect flag enabled by defining IF_FAULT_CHECK_EN.
module if_fetch_unit
    import if_fetch_unit_pkg::*;
#(
    parameter int unsigned           ADDR_WIDTH = 32,
    parameter int unsigned           DATA_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] PC_ADDR    = 32'h8000_0000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [1:0]            pc_stall_and_flush,
    input  logic [ADDR_WIDTH-1:0] branch_target,
    if_fetch_unit_if.master       wb,
    output logic [ADDR_WIDTH-1:0] if_pc,
    output logic [DATA_WIDTH-1:0] if_inst,
    output logic                  if_valid,
    output logic                  im_busy,
    output logic                  if_fault
);

    fetch_state_e          state_q, state_d;
    logic [ADDR_WIDTH-1:0] pc_q, pc_d, target;
    logic [DATA_WIDTH-1:0] inst_q, inst_d, bus_data;
    logic                  stall, flush, bus_start, bus_ack, bus_busy;

    assign stall  = pc_stall_and_flush[STALL_BIT];
    assign flush  = pc_stall_and_flush[FLUSH_BIT];
    assign target = branch_target & ~ADDR_WIDTH'(INST_BYTES - 1);

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        inst_d  = inst_q;
        unique case (state_q)
            StStart: state_d = StFetch;
            StFetch: begin
                if (flush) begin
                    pc_d    = target;
                    state_d = bus_ack ? StFetch : StDiscard;
                end else if (bus_ack) begin
                    inst_d  = bus_data;
                    state_d = StDone;
                end
            end
            StDone: begin
                if (flush) begin
                    pc_d    = target;
                    state_d = StFetch;
                end else if (!stall) begin
                    pc_d    = pc_q + ADDR_WIDTH'(INST_BYTES);
                    state_d = StFetch;
                end
            end
            StDiscard: begin
                // The latest redirect wins; the stale transfer still runs to its ack.
                if (flush) begin
                    pc_d = target;
                end
                if (bus_ack) begin
                    state_d = StFetch;
                end
            end
            default: state_d = StStart;
        endcase
        bus_start = (state_d == StFetch) && ((state_q != StFetch) || bus_ack);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StStart;
            pc_q    <= PC_ADDR;
            inst_q  <= DATA_WIDTH'(NOP_INST);
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            inst_q  <= inst_d;
        end
    end

    if_wb_master #(
        .ADDR_WIDTH(ADDR_WIDTH),
        .DATA_WIDTH(DATA_WIDTH)
    ) u_wb_master (
        .clk    (clk),
        .reset  (reset),
        .start_i(bus_start),
        .addr_i (pc_d),
        .ack_o  (bus_ack),
        .data_o (bus_data),
        .busy_o (bus_busy),
        .wb     (wb)
    );

    assign if_pc    = pc_q;
    assign if_valid = (state_q == StDone);
    assign im_busy  = (state_q != StDone);
    assign if_inst  = if_valid ? inst_q : DATA_WIDTH'(NOP_INST);

`ifdef IF_FAULT_CHECK_EN
    logic fault_q, fault_d;

    // Sticky until the instruction fetched from the redirect leaves DONE.
    always_comb begin
        fault_d = fault_q;
        if (state_q == StDone && (flush || !stall)) begin
            fault_d = 1'b0;
        end
        if (flush && state_q != StStart) begin
            fault_d = |branch_target[1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fault_q <= 1'b0;
        end else begin
            fault_q <= fault_d;
        end
    end

    assign if_fault = fault_q && (state_q == StDone);
`else
    assign if_fault = 1'b0;
`endif

    a_bus_open_while_fetching : assert property (@(posedge clk) disable iff (reset)
        (state_q inside {StFetch, StDiscard}) |-> bus_busy);

endmodule

// File: tb/tb_if_fetch_unit.sv
// Scoreboard bench for if_fetch_unit: directed stall/flush/wait-state/reset sequences.
module tb_if_fetch_unit;

    localparam logic [31:0] NOP = 32'h0000_0013;
`ifdef IF_FAULT_CHECK_EN
    localparam logic FaultOn = 1'b1;
`else
    localparam logic FaultOn = 1'b0;
`endif

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        fault;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  pc_stall_and_flush;
    logic [31:0] branch_target;
    logic [31:0] if_pc;
    logic [31:0] if_inst;
    logic        if_valid;
    logic        im_busy;
    logic        if_fault;

    int          n_total = 0;
    int          n_pass  = 0;
    bit          mon_en  = 1'b0;
    int unsigned waits   = 0;
    bit          late_ack = 1'b0;

    logic [31:0] addr_q[$];
    exp_t        exp_q[$];

    if_fetch_unit_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) wb ();

    if_fetch_unit #(
        .ADDR_WIDTH(32),
        .DATA_WIDTH(32),
        .PC_ADDR   (32'h8000_0000)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .pc_stall_and_flush(pc_stall_and_flush),
        .branch_target     (branch_target),
        .wb                (wb),
        .if_pc             (if_pc),
        .if_inst           (if_inst),
        .if_valid          (if_valid),
        .im_busy           (im_busy),
        .if_fault          (if_fault)
    );

    initial forever #5 clk = ~clk;

    function automatic logic [31:0] mem(input logic [31:0] a);
        return {a[15:0], 16'h0093};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    endtask

    task automatic push_fetch(input logic [31:0] a, input logic [31:0] inst, input logic flt);
        addr_q.push_back(a);
        exp_q.push_back('{pc: a, inst: inst, fault: flt});
    endtask

    task automatic wait_valid(input logic [31:0] pc);
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (if_valid && if_pc == pc) break;
        end
        check("reach_valid_pc", {if_valid, if_pc}, {1'b1, pc});
    endtask

    // Slave: ack after `waits` stall cycles; never acks two cycles back to back.
    initial begin
        int unsigned cnt = 0;
        logic        ack_n;
        wb.wb_ack_i = 1'b0;
        wb.wb_dat_i = '0;
        forever begin
            @(posedge clk);
            #1;
            ack_n = 1'b0;
            if (wb.wb_stb_o && !wb.wb_ack_i) begin
                if (cnt == waits) begin
                    ack_n       = 1'b1;
                    wb.wb_dat_i = mem(wb.wb_adr_o);
                    cnt         = 0;
                end else begin
                    cnt++;
                end
            end else begin
                cnt = 0;
            end
            wb.wb_ack_i = ack_n | late_ack;
        end
    end

    // Monitor: pops expectations on each new bus transfer and each newly valid instruction.
    initial begin
        logic        stb_prev = 1'b0;
        logic        ack_prev = 1'b0;
        logic        vld_prev = 1'b0;
        logic [31:0] a;
        exp_t        e;
        wait (mon_en);
        forever begin
            @(negedge clk);
            check("valid_while_busy", {31'd0, if_valid & im_busy}, 0);
            if (!if_valid) check("nop_when_invalid", if_inst, NOP);
            if (wb.wb_stb_o && (!stb_prev || ack_prev)) begin
                if (addr_q.size() == 0) begin
                    n_total++;
                    $display("FAIL unexpected_fetch: got adr 0x%0h, required no bus cycle",
                             wb.wb_adr_o);
                end else begin
                    a = addr_q.pop_front();
                    check("fetch_addr", wb.wb_adr_o, a);
                    check("we_sel_cyc", {wb.wb_we_o, wb.wb_sel_o, wb.wb_cyc_o},
                          {1'b0, 4'hF, 1'b1});
                end
            end
            if (if_valid && !vld_prev) begin
                if (exp_q.size() == 0) begin
                    n_total++;
                    $display("FAIL unexpected_valid: got pc 0x%0h, required none", if_pc);
                end else begin
                    e = exp_q.pop_front();
                    check("if_pc", if_pc, e.pc);
                    check("if_inst", if_inst, e.inst);
                    check("if_fault", {63'd0, if_fault}, {63'd0, e.fault});
                end
            end
            stb_prev = wb.wb_stb_o;
            ack_prev = wb.wb_ack_i;
            vld_prev = if_valid;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish, required finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int busy_cnt;
        reset              = 1'b1;
        pc_stall_and_flush = 2'b00;
        branch_target      = '0;
        @(negedge clk);
        mon_en = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("rst_stb", {wb.wb_cyc_o, wb.wb_stb_o}, 2'b00);
        check("rst_valid", {63'd0, if_valid}, 0);
        check("rst_inst", if_inst, NOP);
        check("rst_busy", {63'd0, im_busy}, 1);
        check("rst_pc", if_pc, 32'h8000_0000);
        check("rst_fault", {63'd0, if_fault}, 0);

        // Zero-wait slave, straight-line fetch.
        push_fetch(32'h8000_0000, 32'h0000_0093, 1'b0);
        push_fetch(32'h8000_0004, 32'h0004_0093, 1'b0);
        push_fetch(32'h8000_0008, 32'h0008_0093, 1'b0);
        reset = 1'b0;
        @(negedge clk);
        check("first_stb", {wb.wb_stb_o, wb.wb_adr_o}, {1'b1, 32'h8000_0000});
        @(negedge clk);
        check("zero_wait_valid", {if_valid, if_pc}, {1'b1, 32'h8000_0000});
        wait_valid(32'h8000_0008);

        // Stall held five cycles in DONE.
        waits              = 3;
        pc_stall_and_flush = 2'b01;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("stall_pc", if_pc, 32'h8000_0008);
            check("stall_inst", if_inst, 32'h0008_0093);
            check("stall_valid", {63'd0, if_valid}, 1);
            check("stall_no_bus", {63'd0, wb.wb_stb_o}, 0);
        end
        push_fetch(32'h8000_000C, 32'h000C_0093, 1'b0);
        pc_stall_and_flush = 2'b00;

        // Three wait states: four busy cycles per fetch.
        busy_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (im_busy) busy_cnt++;
            else break;
        end
        check("busy_cycles_3ws", busy_cnt, 4);

        // Flush during FETCH without ack: the in-flight data is dropped.
        waits = 2;
        addr_q.push_back(32'h8000_0010);
        push_fetch(32'h8000_0100, 32'h0100_0093, 1'b0);
        @(negedge clk);
        pc_stall_and_flush = 2'b10;
        branch_target      = 32'h8000_0100;
        @(negedge clk);
        pc_stall_and_flush = 2'b00;
        check("discard_holds_stb", {wb.wb_stb_o, wb.wb_adr_o}, {1'b1, 32'h8000_0010});
        wait_valid(32'h8000_0100);

        // Stall and flush together: redirect wins; then flush coincident with ack.
        waits = 0;
        push_fetch(32'h8000_0200, 32'h0200_0093, 1'b0);
        push_fetch(32'h8000_0204, 32'h0204_0093, 1'b0);
        addr_q.push_back(32'h8000_0208);
        push_fetch(32'h8000_0300, 32'h0300_0093, 1'b0);
        pc_stall_and_flush = 2'b11;
        branch_target      = 32'h8000_0200;
        @(negedge clk);
        pc_stall_and_flush = 2'b00;
        wait_valid(32'h8000_0204);
        @(negedge clk);
        check("ack_with_flush", {wb.wb_stb_o, wb.wb_ack_i}, 2'b11);
        pc_stall_and_flush = 2'b10;
        branch_target      = 32'h8000_0300;
        @(negedge clk);
        pc_stall_and_flush = 2'b00;
        wait_valid(32'h8000_0300);

        // Misaligned redirect.
        push_fetch(32'h8000_0100, 32'h0100_0093, FaultOn);
        push_fetch(32'h8000_0104, 32'h0104_0093, 1'b0);
        pc_stall_and_flush = 2'b10;
        branch_target      = 32'h8000_0102;
        @(negedge clk);
        pc_stall_and_flush = 2'b00;
        wait_valid(32'h8000_0104);

        // PC wrap at the top of the address space.
        push_fetch(32'hFFFF_FFFC, 32'hFFFC_0093, 1'b0);
        push_fetch(32'h0000_0000, 32'h0000_0093, 1'b0);
        pc_stall_and_flush = 2'b10;
        branch_target      = 32'hFFFF_FFFC;
        @(negedge clk);
        pc_stall_and_flush = 2'b00;
        wait_valid(32'h0000_0000);

        // Reset mid-transaction, with a late ack during reset/START.
        waits = 3;
        addr_q.push_back(32'h0000_0004);
        push_fetch(32'h8000_0000, 32'h0000_0093, 1'b0);
        @(negedge clk);
        reset    = 1'b1;
        late_ack = 1'b1;
        @(negedge clk);
        check("reset_drops_stb", {wb.wb_cyc_o, wb.wb_stb_o}, 2'b00);
        check("reset_pc", if_pc, 32'h8000_0000);
        check("reset_busy", {if_valid, im_busy}, 2'b01);
        @(negedge clk);
        reset    = 1'b0;
        late_ack = 1'b0;
        wait_valid(32'h8000_0000);
        pc_stall_and_flush = 2'b01;
        repeat (4) @(negedge clk);
        check("addr_queue_drained", addr_q.size(), 0);
        check("inst_queue_drained", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
